// File: rtl/dice_roller.sv
// Multi-die odometer roller: faces spin while roll is held, settle, then freeze.
// Publishes per-die faces, their sum, a doubles flag and a one-cycle result strobe.
module dice_roller #(
    parameter int NUM_DICE      = 2,
    parameter int FACE_MIN      = 1,
    parameter int FACE_MAX      = 6,
    parameter int FACE_W        = 3,
    parameter int SUM_W         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         roll,
    input  logic                         clear,
    output logic [NUM_DICE*FACE_W-1:0]   faces,
    output logic [SUM_W-1:0]             sum,
    output logic                         doubles,
    output logic                         result_valid,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, SPIN, SETTLE, DONE} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [FACE_W-1:0] FMIN = FACE_W'(FACE_MIN);
    localparam logic [FACE_W-1:0] FMAX = FACE_W'(FACE_MAX);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FACE_W-1:0] face_q  [NUM_DICE];
    logic [FACE_W-1:0] stepped [NUM_DICE];
    logic              carry;

    // Odometer step: a die moves only when every lower die sits at FACE_MAX.
    always_comb begin
        carry = 1'b1;
        for (int k = 0; k < NUM_DICE; k++) begin
            stepped[k] = face_q[k];
            if (carry) begin
                if (face_q[k] < FMIN || face_q[k] >= FMAX)
                    stepped[k] = FMIN;
                else
                    stepped[k] = face_q[k] + FACE_W'(1);
            end
            carry = carry && (face_q[k] == FMAX);
        end
    end

    always_comb begin
        sum     = '0;
        doubles = 1'b1;
        for (int k = 0; k < NUM_DICE; k++) begin
            sum = sum + SUM_W'(face_q[k]);
            if (face_q[k] != face_q[0])
                doubles = 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_DICE; k++) begin : g_face
        assign faces[k*FACE_W +: FACE_W] = face_q[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            for (int k = 0; k < NUM_DICE; k++)
                face_q[k] <= FMIN;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (roll) begin
                        state <= SPIN;
                        busy  <= 1'b1;
                    end
                end
                SPIN: begin
                    face_q <= stepped;
                    if (!roll) begin
                        if (SETTLE_CYCLES == 0) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            state <= SETTLE;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                SETTLE: begin
                    face_q <= stepped;
                    if (roll) begin
                        state <= SPIN;
                    end else if (cnt == '0) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // A new roll takes priority over clearing the last result.
                    if (roll) begin
                        state <= SPIN;
                        busy  <= 1'b1;
                    end else if (clear) begin
                        state <= IDLE;
                        for (int k = 0; k < NUM_DICE; k++)
                            face_q[k] <= FMIN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller (2 dice, faces 1..6, settle 4).
// Reference: a roll of H held edges yields H+4 advances of a base-6 counter.
module tb_dice_roller;

    localparam int ND = 2;
    localparam int FW = 3;
    localparam int SW = 4;
    localparam int SC = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             roll = 1'b0;
    logic             clear = 1'b0;
    logic [ND*FW-1:0] faces;
    logic [SW-1:0]    sum;
    logic             doubles;
    logic             result_valid;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int rv_cnt = 0;
    int adv = 0;

    dice_roller #(
        .NUM_DICE(ND), .FACE_MIN(1), .FACE_MAX(6),
        .FACE_W(FW), .SUM_W(SW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .roll(roll), .clear(clear),
        .faces(faces), .sum(sum), .doubles(doubles),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [ND*FW-1:0] exp_faces(input int a);
        int idx;
        idx = a % 36;
        return {3'(1 + idx / 6), 3'(1 + idx % 6)};
    endfunction

    function automatic logic [SW-1:0] exp_sum(input int a);
        int idx;
        idx = a % 36;
        return SW'(2 + idx % 6 + idx / 6);
    endfunction

    function automatic logic exp_dbl(input int a);
        int idx;
        idx = a % 36;
        return (idx % 6) == (idx / 6);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (result_valid) rv_cnt++;
    endtask

    task automatic apply_reset();
        roll = 1'b0;
        clear = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        adv = 0;
    endtask

    // Hold roll for h edges, release, wait for the result strobe.
    task automatic do_roll(input int h, output int lat);
        int start;
        start = rv_cnt;
        roll = 1'b1;
        repeat (h) step();
        roll = 1'b0;
        lat = 0;
        while (rv_cnt == start && lat < 40) begin
            step();
            lat++;
        end
        adv += h + SC;
        tests++;
        if (rv_cnt == start) begin
            fails++;
            $display("FAIL roll_timeout h=%0d: no result_valid after %0d edges", h, lat);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (faces !== exp_faces(0) || sum !== 4'd2 || doubles !== 1'b1) begin
            fails++;
            $display("FAIL reset_faces: got faces=%h sum=%0d dbl=%b want faces=%h sum=2 dbl=1",
                     faces, sum, doubles, exp_faces(0));
        end
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got busy=%b rv=%b want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_single();
        int lat;
        apply_reset();
        do_roll(1, lat);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL single_latency: got %0d edges after release want 5", lat);
        end
        tests++;
        if (faces !== exp_faces(adv) || sum !== exp_sum(adv) || doubles !== exp_dbl(adv)) begin
            fails++;
            $display("FAIL single_result: got faces=%h sum=%0d dbl=%b want faces=%h sum=%0d dbl=%b",
                     faces, sum, doubles, exp_faces(adv), exp_sum(adv), exp_dbl(adv));
        end
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_flags: got busy=%b rv=%b want 0 1", busy, result_valid);
        end
        step();
        tests++;
        if (result_valid !== 1'b0 || faces !== exp_faces(adv)) begin
            fails++;
            $display("FAIL single_pulse: got rv=%b faces=%h want rv=0 faces=%h",
                     result_valid, faces, exp_faces(adv));
        end
    endtask

    task automatic test_carry_wrap();
        int lat;
        apply_reset();
        do_roll(3, lat);
        tests++;
        if (faces !== 6'o22 || sum !== 4'd4 || doubles !== 1'b1) begin
            fails++;
            $display("FAIL carry: got faces=%h sum=%0d dbl=%b want faces=12 sum=4 dbl=1",
                     faces, sum, doubles);
        end
        apply_reset();
        do_roll(32, lat);
        tests++;
        if (faces !== 6'o11 || sum !== 4'd2) begin
            fails++;
            $display("FAIL full_wrap: got faces=%h sum=%0d want faces=09 sum=2", faces, sum);
        end
    endtask

    task automatic test_random_rolls();
        int lat;
        int h;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(1, 50);
            do_roll(h, lat);
            tests++;
            if (faces !== exp_faces(adv) || sum !== exp_sum(adv) || doubles !== exp_dbl(adv)) begin
                fails++;
                $display("FAIL random_roll%0d h=%0d: got faces=%h sum=%0d dbl=%b want faces=%h sum=%0d dbl=%b",
                         i, h, faces, sum, doubles, exp_faces(adv), exp_sum(adv), exp_dbl(adv));
            end
        end
    endtask

    task automatic test_reroll();
        int h1;
        int h2;
        int rv0;
        int n;
        for (int i = 0; i < 3; i++) begin
            apply_reset();
            h1 = $urandom_range(1, 10);
            h2 = $urandom_range(1, 10);
            rv0 = rv_cnt;
            roll = 1'b1;
            repeat (h1) step();
            roll = 1'b0;
            repeat (3) step();
            roll = 1'b1;
            repeat (h2) step();
            roll = 1'b0;
            n = 0;
            while (rv_cnt == rv0 && n < 40) begin
                step();
                n++;
            end
            repeat (3) step();
            adv = h1 + 3 + h2 + SC;
            tests++;
            if (rv_cnt - rv0 !== 1) begin
                fails++;
                $display("FAIL reroll_pulses%0d: got %0d result_valid pulses want 1", i, rv_cnt - rv0);
            end
            tests++;
            if (faces !== exp_faces(adv)) begin
                fails++;
                $display("FAIL reroll_result%0d h1=%0d h2=%0d: got faces=%h want %h",
                         i, h1, h2, faces, exp_faces(adv));
            end
        end
    endtask

    task automatic test_clear();
        int lat;
        apply_reset();
        do_roll(4, lat);
        clear = 1'b1;
        step();
        clear = 1'b0;
        adv = 0;
        tests++;
        if (faces !== exp_faces(0) || busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear: got faces=%h busy=%b rv=%b want faces=%h busy=0 rv=0",
                     faces, busy, result_valid, exp_faces(0));
        end
        repeat (3) step();
        tests++;
        if (faces !== exp_faces(0) || busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_idle: got faces=%h busy=%b want faces=%h busy=0",
                     faces, busy, exp_faces(0));
        end
        do_roll(2, lat);
        roll = 1'b1;
        clear = 1'b1;
        step();
        roll = 1'b0;
        clear = 1'b0;
        tests++;
        if (busy !== 1'b1 || faces !== exp_faces(adv)) begin
            fails++;
            $display("FAIL roll_beats_clear: got busy=%b faces=%h want busy=1 faces=%h",
                     busy, faces, exp_faces(adv));
        end
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        adv += 1 + SC;
        tests++;
        if (faces !== exp_faces(adv) || result_valid !== 1'b1) begin
            fails++;
            $display("FAIL roll_beats_clear_result: got faces=%h rv=%b want faces=%h rv=1",
                     faces, result_valid, exp_faces(adv));
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        roll = 1'b1;
        repeat (4) step();
        tests++;
        if (busy !== 1'b1 || faces !== exp_faces(3)) begin
            fails++;
            $display("FAIL spin_busy: got busy=%b faces=%h want busy=1 faces=%h",
                     busy, faces, exp_faces(3));
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (faces !== exp_faces(0) || busy !== 1'b0 || result_valid !== 1'b0 || sum !== 4'd2) begin
            fails++;
            $display("FAIL async_reset: got faces=%h busy=%b rv=%b sum=%0d want faces=%h busy=0 rv=0 sum=2",
                     faces, busy, result_valid, sum, exp_faces(0));
        end
        roll = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();
        tests++;
        if (faces !== exp_faces(0) || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got faces=%h busy=%b want faces=%h busy=0",
                     faces, busy, exp_faces(0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry_wrap();
        test_random_rolls();
        test_reroll();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
